// File: rtl/truss_watchdog_array.sv
// truss_watchdog_array
//   Array of independent programmable watchdog channels sharing one prescaled
//   time base. Each channel counts down on prescaler ticks, can be kicked to
//   reload, and on expiry either reloads (auto_restart) or parks in EXPIRED.
//   Expiries set a sticky status bit; a registered shutdown request is raised
//   while at least SHUTDOWN_THRESHOLD channels have sticky status set.
//
// Ports
//   clk            : system clock, rising edge
//   reset_n        : asynchronous active-low reset
//   prescale       : tick period minus one
//   arm/disarm/kick/clear_expired : per-channel 1-cycle strobes
//   auto_restart   : per-channel mode (1 = reload on expiry)
//   timeout_value  : per-channel timeout, channel i at [i*COUNT_WIDTH +: COUNT_WIDTH]
//   active         : channel is ARMED
//   expired_pulse  : one-cycle pulse per expiry event
//   status_expired : sticky expiry flag
//   any_expired    : OR of status_expired
//   shutdown_req   : popcount(status_expired) >= SHUTDOWN_THRESHOLD (registered)
module truss_watchdog_array #(
  parameter int unsigned NUM_CHANNELS       = 4,
  parameter int unsigned COUNT_WIDTH        = 16,
  parameter int unsigned PRESCALE_WIDTH     = 8,
  parameter int unsigned SHUTDOWN_THRESHOLD = 1
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [PRESCALE_WIDTH-1:0]           prescale,
  input  logic [NUM_CHANNELS-1:0]             arm,
  input  logic [NUM_CHANNELS-1:0]             disarm,
  input  logic [NUM_CHANNELS-1:0]             kick,
  input  logic [NUM_CHANNELS-1:0]             auto_restart,
  input  logic [NUM_CHANNELS*COUNT_WIDTH-1:0] timeout_value,
  input  logic [NUM_CHANNELS-1:0]             clear_expired,
  output logic [NUM_CHANNELS-1:0]             active,
  output logic [NUM_CHANNELS-1:0]             expired_pulse,
  output logic [NUM_CHANNELS-1:0]             status_expired,
  output logic                                any_expired,
  output logic                                shutdown_req
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_EXPIRED = 2'd2
  } state_e;

  state_e                    state_q [NUM_CHANNELS];
  state_e                    state_d [NUM_CHANNELS];
  logic [COUNT_WIDTH-1:0]    count_q [NUM_CHANNELS];
  logic [COUNT_WIDTH-1:0]    count_d [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]   pulse_q, pulse_d;
  logic [NUM_CHANNELS-1:0]   status_q, status_d;
  logic                      shutdown_q, shutdown_d;
  logic [PRESCALE_WIDTH-1:0] pcnt_q, pcnt_d;
  logic                      tick;
  logic [6:0]                pop;

  // Prescaler: tick only on exact match; a count left above a freshly
  // lowered prescale wraps to 0 without producing a tick.
  always_comb begin
    tick = (pcnt_q == prescale);
    if (pcnt_q >= prescale) pcnt_d = '0;
    else                    pcnt_d = pcnt_q + 1'b1;
  end

  // Per-channel next state. Priority: disarm > arm > kick > tick.
  always_comb begin
    pulse_d  = '0;
    status_d = '0;
    active   = '0;
    pop      = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      state_d[i] = state_q[i];
      count_d[i] = count_q[i];
      active[i]  = (state_q[i] == ST_ARMED);
      unique case (state_q[i])
        ST_IDLE: begin
          if (!disarm[i] && arm[i]) begin
            count_d[i] = timeout_value[i*COUNT_WIDTH +: COUNT_WIDTH];
            state_d[i] = ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (disarm[i]) begin
            state_d[i] = ST_IDLE;
            count_d[i] = '0;
          end else if (arm[i] || kick[i]) begin
            count_d[i] = timeout_value[i*COUNT_WIDTH +: COUNT_WIDTH];
          end else if (tick) begin
            if (count_q[i] != '0) begin
              count_d[i] = count_q[i] - 1'b1;
            end else begin
              pulse_d[i] = 1'b1;
              if (auto_restart[i]) count_d[i] = timeout_value[i*COUNT_WIDTH +: COUNT_WIDTH];
              else                 state_d[i] = ST_EXPIRED;
            end
          end
        end
        ST_EXPIRED: begin
          if (disarm[i]) begin
            state_d[i] = ST_IDLE;
            count_d[i] = '0;
          end else if (arm[i]) begin
            count_d[i] = timeout_value[i*COUNT_WIDTH +: COUNT_WIDTH];
            state_d[i] = ST_ARMED;
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          count_d[i] = '0;
        end
      endcase
      // A same-cycle expiry overrides the clear.
      status_d[i] = pulse_d[i] | (status_q[i] & ~clear_expired[i]);
      pop         = pop + 7'(status_d[i]);
    end
    // Built from next-state status so shutdown_req rises with the pulse.
    shutdown_d = (pop >= 7'(SHUTDOWN_THRESHOLD));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt_q     <= '0;
      pulse_q    <= '0;
      status_q   <= '0;
      shutdown_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        state_q[i] <= ST_IDLE;
        count_q[i] <= '0;
      end
    end else begin
      pcnt_q     <= pcnt_d;
      pulse_q    <= pulse_d;
      status_q   <= status_d;
      shutdown_q <= shutdown_d;
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        count_q[i] <= count_d[i];
      end
    end
  end

  assign expired_pulse  = pulse_q;
  assign status_expired = status_q;
  assign any_expired    = |status_q;
  assign shutdown_req   = shutdown_q;

endmodule
